// File: rtl/lsq_if.sv
// Data-port bus between the load/store queue (master) and the memory side (slave).
// Carries the request channel and the in-order response channel.
interface lsq_if #(
  parameter int C_XLEN = 32
);
  logic                  dreqready;
  logic                  dreqvalid;
  logic [1:0]            dreqhpl;
  logic                  dreqwr;
  logic [C_XLEN/8-1:0]   dreqbe;
  logic [C_XLEN-1:0]     dreqaddr;
  logic [C_XLEN-1:0]     dreqdata;
  logic                  drspready;
  logic                  drspvalid;
  logic                  drsprerr;
  logic                  drspwerr;
  logic [C_XLEN-1:0]     drspdata;

  modport master (
    input  dreqready,
    output dreqvalid, dreqhpl, dreqwr, dreqbe, dreqaddr, dreqdata,
    output drspready,
    input  drspvalid, drsprerr, drspwerr, drspdata
  );

  modport slave (
    output dreqready,
    input  dreqvalid, dreqhpl, dreqwr, dreqbe, dreqaddr, dreqdata,
    input  drspready,
    output drspvalid, drsprerr, drspwerr, drspdata
  );
endinterface

// File: rtl/lsq.sv
// In-order load/store queue: buffers ex-stage memory ops, issues them on the data port,
// retires responses in order, writes load results back and reports access faults.
module lsq #(
  parameter int C_XLEN    = 32,
  parameter int C_DEPTH_X = 2
) (
  input  logic                clk_i,
  input  logic                resetb_i,
  input  logic                clk_en_i,
  output logic                exs_full_o,
  input  logic                exs_lq_wr_i,
  input  logic                exs_sq_wr_i,
  input  logic [2:0]          exs_funct3_i,
  input  logic [4:0]          exs_regd_addr_i,
  input  logic [C_XLEN-1:0]   exs_regs2_data_i,
  input  logic [C_XLEN-1:0]   exs_addr_i,
  lsq_if.master               dbus,
  output logic                ids_reg_wr_o,
  output logic [4:0]          ids_reg_addr_o,
  output logic [C_XLEN-1:0]   ids_reg_data_o,
  output logic                hvec_err_o,
  output logic [1:0]          hvec_err_cause_o,
  output logic [C_XLEN-1:0]   hvec_err_addr_o
);
  localparam int DEPTH = 1 << C_DEPTH_X;
  localparam int PW    = C_DEPTH_X + 1;
  localparam int NB    = C_XLEN / 8;
  localparam int OFFW  = $clog2(NB);

  typedef logic [PW-1:0]        ptr_t;
  typedef logic [C_DEPTH_X-1:0] idx_t;

  ptr_t wp, ip, rp, count;
  idx_t wi, ii, ri;

  logic              q_st   [DEPTH];
  logic              q_mis  [DEPTH];
  logic [2:0]        q_f3   [DEPTH];
  logic [4:0]        q_rd   [DEPTH];
  logic [C_XLEN-1:0] q_data [DEPTH];
  logic [C_XLEN-1:0] q_addr [DEPTH];

  logic in_illegal, in_mis, enq;
  logic ip_has, ip_mis, ip_adv;
  logic rp_has, rp_mis, rsp_fire, mis_ret, rp_adv;

  logic [OFFW-1:0]   req_off, rsp_off;
  logic [1:0]        req_sz;
  logic [NB-1:0]     req_be;
  logic [C_XLEN-1:0] req_data, rsp_shift, ld_val;
  logic              rsp_sign;
  int                rsp_nbits;

  function automatic logic [OFFW-1:0] lsb_mask(input logic [1:0] sz);
    logic [3:0] m;
    m = (4'd1 << sz) - 4'd1;
    return m[OFFW-1:0];
  endfunction

  assign wi = wp[C_DEPTH_X-1:0];
  assign ii = ip[C_DEPTH_X-1:0];
  assign ri = rp[C_DEPTH_X-1:0];

  assign count      = wp - rp;
  assign exs_full_o = (count == ptr_t'(DEPTH));

  // Doubles and LWU only exist on RV64; on RV32 they fault like a misaligned access.
  assign in_illegal = (C_XLEN == 32) &&
                      ((exs_funct3_i[1:0] == 2'd3) || (exs_funct3_i == 3'b110));
  assign in_mis     = in_illegal ||
                      ((exs_addr_i[OFFW-1:0] & lsb_mask(exs_funct3_i[1:0])) != '0);
  assign enq        = clk_en_i && !exs_full_o && (exs_lq_wr_i || exs_sq_wr_i);

  assign ip_has         = (ip != wp);
  assign ip_mis         = q_mis[ii];
  assign dbus.dreqvalid = ip_has && !ip_mis;
  assign ip_adv         = clk_en_i && ip_has && (ip_mis || dbus.dreqready);

  // Misaligned entries never reach the bus, so a response is never matched against one.
  assign rp_has         = (rp != ip);
  assign rp_mis         = q_mis[ri];
  assign dbus.drspready = rp_has && !rp_mis;
  assign rsp_fire       = clk_en_i && dbus.drspready && dbus.drspvalid;
  assign mis_ret        = clk_en_i && rp_has && rp_mis;
  assign rp_adv         = rsp_fire || mis_ret;

  assign dbus.dreqhpl = 2'b11;

  always_comb begin
    req_sz   = q_f3[ii][1:0];
    req_off  = q_addr[ii][OFFW-1:0];
    req_be   = '0;
    req_data = '0;
    for (int b = 0; b < NB; b++)
      req_be[b] = (b >= int'(req_off)) && (b < int'(req_off) + (1 << req_sz));
    for (int i = 0; i < C_XLEN; i++)
      req_data[i] = q_data[ii][i % (8 << req_sz)];
  end

  assign dbus.dreqwr   = dbus.dreqvalid && q_st[ii];
  assign dbus.dreqbe   = dbus.dreqvalid ? req_be : '0;
  assign dbus.dreqdata = dbus.dreqvalid ? req_data : '0;
  assign dbus.dreqaddr = dbus.dreqvalid ? {q_addr[ii][C_XLEN-1:OFFW], {OFFW{1'b0}}} : '0;

  always_comb begin
    rsp_off   = q_addr[ri][OFFW-1:0];
    rsp_nbits = 8 << q_f3[ri][1:0];
    rsp_shift = dbus.drspdata >> {rsp_off, 3'b000};
    rsp_sign  = 1'b0;
    ld_val    = '0;
    if (!q_f3[ri][2] && rsp_nbits <= C_XLEN)
      rsp_sign = rsp_shift[rsp_nbits-1];
    for (int i = 0; i < C_XLEN; i++)
      ld_val[i] = (i < rsp_nbits) ? rsp_shift[i] : rsp_sign;
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      q_st[wi]   <= exs_sq_wr_i;
      q_mis[wi]  <= in_mis;
      q_f3[wi]   <= exs_funct3_i;
      q_rd[wi]   <= exs_regd_addr_i;
      q_data[wi] <= exs_regs2_data_i;
      q_addr[wi] <= exs_addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      wp               <= '0;
      ip               <= '0;
      rp               <= '0;
      ids_reg_wr_o     <= 1'b0;
      ids_reg_addr_o   <= '0;
      ids_reg_data_o   <= '0;
      hvec_err_o       <= 1'b0;
      hvec_err_cause_o <= '0;
      hvec_err_addr_o  <= '0;
    end else if (clk_en_i) begin
      if (enq)    wp <= wp + 1'b1;
      if (ip_adv) ip <= ip + 1'b1;
      if (rp_adv) rp <= rp + 1'b1;
      ids_reg_wr_o <= 1'b0;
      hvec_err_o   <= 1'b0;
      if (mis_ret) begin
        hvec_err_o       <= 1'b1;
        hvec_err_cause_o <= {1'b0, q_st[ri]};
        hvec_err_addr_o  <= q_addr[ri];
      end else if (rsp_fire) begin
        if (q_st[ri]) begin
          if (dbus.drspwerr) begin
            hvec_err_o       <= 1'b1;
            hvec_err_cause_o <= 2'd3;
            hvec_err_addr_o  <= q_addr[ri];
          end
        end else if (dbus.drsprerr) begin
          hvec_err_o       <= 1'b1;
          hvec_err_cause_o <= 2'd2;
          hvec_err_addr_o  <= q_addr[ri];
        end else if (q_rd[ri] != 5'd0) begin
          ids_reg_wr_o   <= 1'b1;
          ids_reg_addr_o <= q_rd[ri];
          ids_reg_data_o <= ld_val;
        end
      end
    end
  end
endmodule
